// File: rtl/hilo_sched_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : hilo_sched_pkg                                        |
// | Description : Shared encodings for the HI/LO scheduler: request    |
// |               opcodes, HI/LO source selects and FSM states.        |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package hilo_sched_pkg;

  // Request opcodes presented by the control unit on req_op
  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  // HI/LO write-source selects
  localparam logic [2:0] SRC_QA    = 3'd0;
  localparam logic [2:0] SRC_MULTU = 3'd1;
  localparam logic [2:0] SRC_MULT  = 3'd2;
  localparam logic [2:0] SRC_DIVU  = 3'd3;
  localparam logic [2:0] SRC_DIV   = 3'd4;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Source select used when a multi-cycle unit writes back its result
  function automatic logic [2:0] op_src(input op_e op);
    logic [2:0] src;
    case (op)
      OP_MULTU: src = SRC_MULTU;
      OP_DIVU:  src = SRC_DIVU;
      OP_DIV:   src = SRC_DIV;
      default:  src = SRC_QA;
    endcase
    return src;
  endfunction

  // True for the two divide opcodes
  function automatic logic is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_tmo_cnt.sv
// +--------------------------------------------------------------------+
// | Module      : hilo_tmo_cnt                                          |
// | Description : Saturating WAIT-cycle counter. tc is high from the   |
// |               last permitted WAIT cycle onward.                    |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module hilo_tmo_cnt #(
  parameter int TMO_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int              CW       = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TMO_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] count;

  // Count enabled cycles, holding at TMO_CYCLES once reached
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of WAIT cycles already completed, so this
  // flags the TMO_CYCLES-th WAIT cycle itself
  assign tc = (count >= CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/hilo_sched.sv
// +--------------------------------------------------------------------+
// | Module      : hilo_sched                                            |
// | Description : HI/LO register write scheduler. Acks CU requests,   |
// |               launches multu/divu/div units, waits for completion, |
// |               then writes HI/LO back. Stalls new requests while a  |
// |               unit is in flight; sticky err on timeout.            |
// | Options     : HILO_SCHED_DIV0_TRAP_EN - trap DIVU/DIV with a zero  |
// |               divisor via div0_exc instead of launching.           |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module hilo_sched
  import hilo_sched_pkg::*;
#(
  parameter int TMO_CYCLES = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic       divisor_zero,
  input  logic       busy_m1,
  input  logic       busy_d1,
  input  logic       busy_d2,
  output logic       start_m1,
  output logic       start_d1,
  output logic       start_d2,
  output logic [2:0] hi_c,
  output logic [2:0] lo_c,
  output logic       ena_hi,
  output logic       ena_lo,
  output logic       req_ack,
  output logic       stall,
  output logic       err,
  output logic       div0_exc
);

  state_e state;
  op_e    cur_op;
  op_e    op_in;
  logic   busy_sel;
  logic   launch;
  logic   div0_hit;
  logic   tmo_tc;

  assign op_in = op_e'(req_op);

`ifdef HILO_SCHED_DIV0_TRAP_EN
  assign div0_hit = is_div(op_in) && divisor_zero;
`else
  // Divisor-zero input has no effect in this build
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
  assign div0_hit            = 1'b0;
`endif

  // Busy flag of the unit the in-flight op was launched on
  always_comb begin
    busy_sel = 1'b0;
    case (cur_op)
      OP_MULTU: busy_sel = busy_m1;
      OP_DIVU:  busy_sel = busy_d1;
      OP_DIV:   busy_sel = busy_d2;
      default:  busy_sel = 1'b0;
    endcase
  end

  // Request decode and write-back outputs; all forced low during reset
  always_comb begin
    start_m1 = 1'b0;
    start_d1 = 1'b0;
    start_d2 = 1'b0;
    hi_c     = SRC_QA;
    lo_c     = SRC_QA;
    ena_hi   = 1'b0;
    ena_lo   = 1'b0;
    req_ack  = 1'b0;
    stall    = 1'b0;
    div0_exc = 1'b0;
    launch   = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ack = 1'b1;
            if (div0_hit) begin
              div0_exc = 1'b1;
            end else begin
              case (op_in)
                OP_MTHI: ena_hi = 1'b1;
                OP_MTLO: ena_lo = 1'b1;
                OP_MULT: begin
                  ena_hi = 1'b1;
                  ena_lo = 1'b1;
                  hi_c   = SRC_MULT;
                  lo_c   = SRC_MULT;
                end
                OP_MULTU: begin
                  start_m1 = 1'b1;
                  launch   = 1'b1;
                end
                OP_DIVU: begin
                  start_d1 = 1'b1;
                  launch   = 1'b1;
                end
                OP_DIV: begin
                  start_d2 = 1'b1;
                  launch   = 1'b1;
                end
                default: ;  // MFHI/MFLO: ack only
              endcase
            end
          end
        end
        ST_WAIT: begin
          stall = req_valid;
        end
        ST_WRITE: begin
          stall  = req_valid;
          ena_hi = 1'b1;
          ena_lo = 1'b1;
          hi_c   = op_src(cur_op);
          lo_c   = op_src(cur_op);
        end
        default: ;
      endcase
    end
  end

  // WAIT-cycle timeout counter, restarted at every launch
  hilo_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (launch),
    .enable (state == ST_WAIT),
    .tc     (tmo_tc)
  );

  // Scheduler FSM: launch -> WAIT until unit idle (or timeout) -> WRITE
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cur_op <= OP_MULTU;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state  <= ST_WAIT;
            cur_op <= op_in;
          end
        end
        ST_WAIT: begin
          if (!busy_sel) begin
            state <= ST_WRITE;
          end else if (tmo_tc) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_sched.sv
// +--------------------------------------------------------------------+
// | Module      : tb_hilo_sched                                         |
// | Description : Self-checking bench for hilo_sched: directed scenes |
// |               followed by random traffic against a cycle model.    |
// |               Honours HILO_SCHED_DIV0_TRAP_EN when defined.        |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hilo_sched;

  localparam int TMO = 40;
`ifdef HILO_SCHED_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic       divisor_zero = 1'b0;
  logic       busy_m1 = 1'b0, busy_d1 = 1'b0, busy_d2 = 1'b0;
  logic       start_m1, start_d1, start_d2;
  logic [2:0] hi_c, lo_c;
  logic       ena_hi, ena_lo, req_ack, stall, err, div0_exc;

  int checks = 0;
  int errors = 0;

  hilo_sched #(.TMO_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .divisor_zero(divisor_zero), .busy_m1(busy_m1), .busy_d1(busy_d1),
    .busy_d2(busy_d2), .start_m1(start_m1), .start_d1(start_d1),
    .start_d2(start_d2), .hi_c(hi_c), .lo_c(lo_c), .ena_hi(ena_hi),
    .ena_lo(ena_lo), .req_ack(req_ack), .stall(stall), .err(err),
    .div0_exc(div0_exc)
  );

  always #5 clock = ~clock;

  // Reference model: which unit op is outstanding, how long it has waited,
  // whether this is its write-back cycle, and the sticky error.
  int m_unit   = -1;   // opcode of in-flight unit op, -1 when none
  int m_waited = 0;
  bit m_write  = 1'b0;
  bit m_err    = 1'b0;
  int rem      = 0;    // remaining busy cycles of the in-flight unit
  int busy_len = 5;    // busy duration given to the next launched unit
  bit rand_len = 1'b0;

  bit e_m1, e_d1, e_d2, e_hi, e_lo, e_ack, e_stall, e_exc, e_launch;
  int e_src;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive unit busy flags, check outputs at negedge, advance model
  task automatic step();
    bit sel;
    busy_m1 = (m_unit == 0) ? (rem > 0) : 1'($urandom_range(0, 1));
    busy_d1 = (m_unit == 2) ? (rem > 0) : 1'($urandom_range(0, 1));
    busy_d2 = (m_unit == 3) ? (rem > 0) : 1'($urandom_range(0, 1));
    @(negedge clock);
    {e_m1, e_d1, e_d2, e_hi, e_lo, e_ack, e_stall, e_exc, e_launch} = '0;
    e_src = 0;
    if (!reset) begin
      if (m_write) begin
        e_hi = 1; e_lo = 1; e_stall = req_valid;
        e_src = (m_unit == 0) ? 1 : (m_unit == 2) ? 3 : 4;
      end else if (m_unit >= 0) begin
        e_stall = req_valid;
      end else if (req_valid) begin
        e_ack = 1;
        if (TRAP && (req_op == 3'd2 || req_op == 3'd3) && divisor_zero) begin
          e_exc = 1;
        end else begin
          case (req_op)
            3'd4: e_hi = 1;
            3'd5: e_lo = 1;
            3'd1: begin e_hi = 1; e_lo = 1; e_src = 2; end
            3'd0: begin e_m1 = 1; e_launch = 1; end
            3'd2: begin e_d1 = 1; e_launch = 1; end
            3'd3: begin e_d2 = 1; e_launch = 1; end
            default: ;
          endcase
        end
      end
    end
    chk("start_m1", 3'(start_m1), 3'(e_m1));
    chk("start_d1", 3'(start_d1), 3'(e_d1));
    chk("start_d2", 3'(start_d2), 3'(e_d2));
    chk("ena_hi",   3'(ena_hi),   3'(e_hi));
    chk("ena_lo",   3'(ena_lo),   3'(e_lo));
    chk("hi_c",     hi_c,         3'(e_src));
    chk("lo_c",     lo_c,         3'(e_src));
    chk("req_ack",  3'(req_ack),  3'(e_ack));
    chk("stall",    3'(stall),    3'(e_stall));
    chk("div0_exc", 3'(div0_exc), 3'(e_exc));
    chk("err",      3'(err),      3'(m_err));
    @(posedge clock);
    sel = (m_unit == 0) ? busy_m1 : (m_unit == 2) ? busy_d1 : busy_d2;
    if (reset) begin
      m_unit = -1; m_write = 0; m_err = 0;
    end else if (m_write) begin
      m_write = 0; m_unit = -1;
    end else if (m_unit >= 0) begin
      m_waited++;
      if (!sel) m_write = 1;
      else if (m_waited >= TMO) begin m_err = 1; m_unit = -1; end
      if (rem > 0) rem--;
    end else if (e_launch) begin
      m_unit = int'(req_op); m_waited = 0;
      rem = rand_len ? int'($urandom_range(0, 45)) : busy_len;
    end
    #1;
    if (e_ack) req_valid = 1'b0;   // CU drops the request once acked
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic [2:0] op, input logic dz);
    req_valid = 1'b1; req_op = op; divisor_zero = dz;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // MTHI in IDLE: same-cycle ack and HI write from qa
    request(3'd4, 1'b0); run(2);
    // MTLO and MULT, both single-cycle
    request(3'd5, 1'b0); run(1);
    request(3'd1, 1'b0); run(2);

    // DIVU with busy_d1 high for 33 cycles
    busy_len = 33;
    request(3'd2, 1'b0); run(38);

    // MULTU then MFLO two cycles later, held through the stall
    busy_len = 10;
    request(3'd0, 1'b0); run(2);
    request(3'd7, 1'b0); run(16);

    // DIV with busy_d2 stuck: timeout, then an MTLO is still accepted
    busy_len = 1000;
    request(3'd3, 1'b0); run(TMO + 4);
    request(3'd5, 1'b0); run(2);

    // Reset in the middle of a WAIT, then MULT
    busy_len = 20;
    request(3'd0, 1'b0); run(6);
    reset = 1'b1; run(1);
    reset = 1'b0; run(1);
    request(3'd1, 1'b0); run(2);

    // DIV with a zero divisor (trap or normal launch depending on build)
    busy_len = 3;
    request(3'd3, 1'b1); run(8);
    request(3'd2, 1'b1); run(8);

    // Random traffic
    rand_len = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!req_valid && $urandom_range(0, 2) == 0)
        request(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
